// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter slice.
// Source indices and default sizes used by the arbiter, its FIFOs and their users.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_ROB_W  = 4;
  localparam int unsigned CDB_N_SRC  = 3;
  localparam int unsigned CDB_DATA_W = 32;

  localparam int unsigned CDB_SRC_ALU = 0;
  localparam int unsigned CDB_SRC_LSB = 1;
  localparam int unsigned CDB_SRC_MD  = 2;

  // Width of an index able to name n sources (never narrower than one bit).
  function automatic int unsigned cdb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO (DEPTH entries, power of two) with flush.
// Push/pop are qualified by the caller; pointers wrap naturally.
module cdb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 36
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy decides what is meaningful.
  always_ff @(posedge clk_in) begin
    if (en && !flush && push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single ROB write-back port among N_SRC producers.
// Optional build macro CDB_STATS_EN adds per-source grant/stall counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = CDB_N_SRC,
  parameter int unsigned ROB_W = CDB_ROB_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          rob_clear,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*ROB_W-1:0]        src_rob_id,
  input  logic [N_SRC*CDB_DATA_W-1:0]   src_val,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          cdb_valid,
  output logic [ROB_W-1:0]              cdb_rob_id,
  output logic [CDB_DATA_W-1:0]         cdb_val,
  output logic [cdb_idx_w(N_SRC)-1:0]   cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]           stat_grants,
  output logic [N_SRC*32-1:0]           stat_stalls
`endif
);

  localparam int unsigned SRC_W = cdb_idx_w(N_SRC);
  localparam int unsigned EW    = ROB_W + CDB_DATA_W;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] nonempty;
  logic [EW-1:0]    head  [N_SRC];
  logic [CW-1:0]    count [N_SRC];
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;

  // Per-source FIFO plus handshake; flush drops same-cycle pushes.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_ready[i] = (count[i] != CW'(DEPTH));
    assign nonempty[i]  = (count[i] != '0);
    assign push[i]      = rdy_in && !rob_clear && src_valid[i] && src_ready[i];
    assign pop[i]       = rdy_in && !rob_clear && gnt_any && (gnt_idx == SRC_W'(i));

    cdb_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (rdy_in),
      .flush  (rob_clear),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    ({src_rob_id[i*ROB_W +: ROB_W], src_val[i*CDB_DATA_W +: CDB_DATA_W]}),
      .head   (head[i]),
      .count  (count[i])
    );
  end

  // First non-empty FIFO head scanning upward from rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!gnt_any && nonempty[SRC_W'((32'(rr_ptr) + k) % N_SRC)]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'((32'(rr_ptr) + k) % N_SRC);
      end
    end
  end

  // Registered CDB and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        cdb_valid <= 1'b0;
        rr_ptr    <= '0;
      end else if (gnt_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= head[gnt_idx][EW-1 -: ROB_W];
        cdb_val    <= head[gnt_idx][CDB_DATA_W-1:0];
        cdb_src    <= gnt_idx;
        rr_ptr     <= SRC_W'((32'(gnt_idx) + 1) % N_SRC);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [31:0] grants_q [N_SRC];
  logic [31:0] stalls_q [N_SRC];

  // Debug counters survive flushes and wrap at 2^32.
  for (genvar i = 0; i < N_SRC; i++) begin : g_stat
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        grants_q[i] <= '0;
        stalls_q[i] <= '0;
      end else begin
        if (pop[i]) grants_q[i] <= grants_q[i] + 32'd1;
        if (rdy_in && src_valid[i] && !src_ready[i]) stalls_q[i] <= stalls_q[i] + 32'd1;
      end
    end
    assign stat_grants[i*32 +: 32] = grants_q[i];
    assign stat_stalls[i*32 +: 32] = stalls_q[i];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a queue-based reference model.
// Build with CDB_STATS_EN defined to also check the statistics counters.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int NS    = 3;
  localparam int RW    = 4;
  localparam int DEPTH = 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              rob_clear;
  logic [NS-1:0]     src_valid;
  logic [NS*RW-1:0]  src_rob_id;
  logic [NS*32-1:0]  src_val;
  logic [NS-1:0]     src_ready;
  logic              cdb_valid;
  logic [RW-1:0]     cdb_rob_id;
  logic [31:0]       cdb_val;
  logic [1:0]        cdb_src;
`ifdef CDB_STATS_EN
  logic [NS*32-1:0]  stat_grants;
  logic [NS*32-1:0]  stat_stalls;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per source plus the expected CDB contents.
  logic [RW+31:0] mq [NS][$];
  int             m_rr;
  logic           m_valid;
  logic [RW-1:0]  m_rob;
  logic [31:0]    m_val;
  int             m_src;
  logic [NS-1:0]  m_acc;
  int unsigned    m_grants [NS];
  int unsigned    m_stalls [NS];

  cdb_arbiter #(.N_SRC(NS), .ROB_W(RW), .DEPTH(DEPTH)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rob_clear  (rob_clear),
    .src_valid  (src_valid),
    .src_rob_id (src_rob_id),
    .src_val    (src_val),
    .src_ready  (src_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .cdb_src    (cdb_src)
`ifdef CDB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NS-1:0] exp_ready();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = (mq[i].size() != DEPTH);
    return r;
  endfunction

  task automatic set_src(input int i, input logic v, input logic [RW-1:0] r, input logic [31:0] d);
    src_valid[i]           = v;
    src_rob_id[i*RW +: RW] = r;
    src_val[i*32 +: 32]    = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mq[i].delete();
      m_grants[i] = 0;
      m_stalls[i] = 0;
    end
    m_rr = 0; m_valid = 1'b0; m_rob = '0; m_val = '0; m_src = 0; m_acc = '0;
  endtask

  // Advance model by one rising edge using the current inputs, then wait for it.
  task automatic tick();
    logic [NS-1:0]  rp;
    int             g;
    logic [RW+31:0] e;
    rp    = exp_ready();
    g     = -1;
    m_acc = '0;
    if (rdy_in) begin
      for (int i = 0; i < NS; i++)
        if (src_valid[i] && !rp[i]) m_stalls[i]++;
      if (rob_clear) begin
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_valid = 1'b0;
        m_rr    = 0;
      end else begin
        for (int k = 0; k < NS; k++)
          if (g < 0 && mq[(m_rr + k) % NS].size() > 0) g = (m_rr + k) % NS;
        if (g >= 0) begin
          e       = mq[g].pop_front();
          m_valid = 1'b1;
          m_rob   = e[RW+31:32];
          m_val   = e[31:0];
          m_src   = g;
          m_rr    = (g + 1) % NS;
          m_grants[g]++;
        end else begin
          m_valid = 1'b0;
        end
        for (int i = 0; i < NS; i++)
          if (src_valid[i] && rp[i]) begin
            mq[i].push_back({src_rob_id[i*RW +: RW], src_val[i*32 +: 32]});
            m_acc[i] = 1'b1;
          end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic apply_reset();
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    src_valid = '0; src_rob_id = '0; src_val = '0;
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b exp=111", src_ready); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
    checks++; if (cdb_rob_id !== 4'd0 || cdb_val !== 32'd0 || cdb_src !== 2'd0) begin
      errors++; $display("FAIL reset_regs rob=%0d val=%h src=%0d exp all zero", cdb_rob_id, cdb_val, cdb_src);
    end
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(i + 1), 32'h100 + 32'(i));
    tick();
    src_valid = '0;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd1) begin
      errors++; $display("FAIL reset_pre valid=%b rob=%0d exp valid=1 rob=1", cdb_valid, cdb_rob_id);
    end
    #1 rst_in = 1'b0;
    #1;
    checks++; if (cdb_valid !== 1'b0 || cdb_rob_id !== 4'd0) begin
      errors++; $display("FAIL reset_async valid=%b rob=%0d exp valid=0 rob=0", cdb_valid, cdb_rob_id);
    end
    #1 rst_in = 1'b1;
    model_reset();
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_release_ready got=%b exp=111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_stale cyc=%0d valid=%b exp=0", c, cdb_valid); end
    end
  endtask

  task automatic test_single_push();
    set_src(1, 1'b1, 4'd5, 32'hDEADBEEF);
    tick();
    src_valid = '0;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_e0 valid=%b exp=0", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd5 || cdb_val !== 32'hDEADBEEF || cdb_src !== 2'd1) begin
      errors++;
      $display("FAIL single_e1 valid=%b rob=%0d val=%h src=%0d exp 1/5/deadbeef/1", cdb_valid, cdb_rob_id, cdb_val, cdb_src);
    end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_e2 valid=%b exp=0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    int nxt [NS];
    int base [NS];
    int gcnt [NS];
    int got;
    apply_reset();
    base = '{1, 4, 8};
    nxt  = base;
    gcnt = '{0, 0, 0};
    got  = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(nxt[i]), 32'(nxt[i]) * 32'h101);
      tick();
      for (int i = 0; i < NS; i++) if (m_acc[i]) nxt[i]++;
      if (cdb_valid === 1'b1) begin
        checks++; if (cdb_src !== 2'(got % 3)) begin
          errors++; $display("FAIL rr_src n=%0d got=%0d exp=%0d", got, cdb_src, got % 3);
        end
        checks++; if (cdb_rob_id !== 4'(base[got % 3] + got / 3)) begin
          errors++; $display("FAIL rr_rob n=%0d got=%0d exp=%0d", got, cdb_rob_id, base[got % 3] + got / 3);
        end
        if (cdb_src < 2'd3) gcnt[cdb_src]++;
        got++;
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL rr_timeout got=%0d results exp=6", got); end
    for (int i = 0; i < NS; i++) begin
      checks++; if (gcnt[i] != 2) begin errors++; $display("FAIL rr_grants src=%0d got=%0d exp=2", i, gcnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    int p0, p1, s2, n2;
    logic [RW-1:0] got2 [3];
    apply_reset();
    p0 = 0; p1 = 6; s2 = 0; n2 = 0;
    for (int c = 0; c < 40 && n2 < 3; c++) begin
      set_src(0, 1'b1, 4'(p0), 32'hA000 + 32'(p0));
      set_src(1, 1'b1, 4'(p1), 32'hA100 + 32'(p1));
      set_src(2, s2 < 3, 4'(12 + s2), 32'hB000 + 32'(s2));
      tick();
      if (m_acc[0]) p0++;
      if (m_acc[1]) p1++;
      if (m_acc[2]) s2++;
      if (c == 1) begin
        checks++; if (src_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", src_ready[2]); end
      end
      checks++; if (src_ready !== exp_ready()) begin
        errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, src_ready, exp_ready());
      end
      checks++; if (cdb_valid !== m_valid) begin
        errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, cdb_valid, m_valid);
      end
      if (cdb_valid === 1'b1 && cdb_src === 2'd2) begin
        got2[n2] = cdb_rob_id;
        n2++;
      end
    end
    checks++; if (n2 != 3) begin errors++; $display("FAIL bp_timeout src2 results got=%0d exp=3", n2); end
    for (int k = 0; k < n2; k++) begin
      checks++; if (got2[k] !== 4'(12 + k)) begin errors++; $display("FAIL bp_order n=%0d got=%0d exp=%0d", k, got2[k], 12 + k); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(i + 1), 32'hC000 + 32'(i));
    tick();
    set_src(0, 1'b1, 4'd4, 32'hC004);
    set_src(1, 1'b1, 4'd5, 32'hC005);
    src_valid[2] = 1'b0;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd1) begin
      errors++; $display("FAIL flush_setup valid=%b rob=%0d exp valid=1 rob=1", cdb_valid, cdb_rob_id);
    end
    src_valid = '0;
    set_src(2, 1'b1, 4'd9, 32'h9999);
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    src_valid = '0;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", cdb_valid); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL flush_empty ready=%b exp=111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale cyc=%0d valid=%b rob=%0d exp valid=0", c, cdb_valid, cdb_rob_id);
      end
    end
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(i + 10), 32'hD000 + 32'(i));
    tick();
    src_valid = '0;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_rob_id !== 4'd10) begin
      errors++; $display("FAIL flush_rr valid=%b src=%0d rob=%0d exp 1/0/10", cdb_valid, cdb_src, cdb_rob_id);
    end
  endtask

  task automatic test_rdy_low();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(c * 3 + i + 1), 32'h5000 + 32'(c * 3 + i));
      tick();
    end
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL frz_setup valid=%b exp=1", cdb_valid); end
    rdy_in = 1'b0;
    rob_clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (cdb_valid !== m_valid || cdb_rob_id !== m_rob || cdb_val !== m_val || cdb_src !== 2'(m_src)) begin
        errors++;
        $display("FAIL frz_cdb cyc=%0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", c, cdb_valid, cdb_rob_id, cdb_val, cdb_src,
                 m_valid, m_rob, m_val, m_src);
      end
      checks++; if (src_ready !== exp_ready()) begin errors++; $display("FAIL frz_ready cyc=%0d got=%b exp=%b", c, src_ready, exp_ready()); end
    end
    rdy_in = 1'b1;
    rob_clear = 1'b0;
    src_valid = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (cdb_valid !== m_valid || (m_valid && (cdb_rob_id !== m_rob || cdb_val !== m_val || cdb_src !== 2'(m_src)))) begin
        errors++;
        $display("FAIL frz_resume cyc=%0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", c, cdb_valid, cdb_rob_id, cdb_val, cdb_src,
                 m_valid, m_rob, m_val, m_src);
      end
    end
`ifdef CDB_STATS_EN
    for (int i = 0; i < NS; i++) begin
      checks++; if (stat_grants[i*32 +: 32] !== 32'(m_grants[i])) begin
        errors++; $display("FAIL frz_grants src=%0d got=%0d exp=%0d", i, stat_grants[i*32 +: 32], m_grants[i]);
      end
      checks++; if (stat_stalls[i*32 +: 32] !== 32'(m_stalls[i])) begin
        errors++; $display("FAIL frz_stalls src=%0d got=%0d exp=%0d", i, stat_stalls[i*32 +: 32], m_stalls[i]);
      end
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 19) == 0);
      tick();
      checks++; if (cdb_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, cdb_valid, m_valid); end
      checks++; if (cdb_rob_id !== m_rob || cdb_val !== m_val) begin
        errors++; $display("FAIL rnd_data cyc=%0d got=%0d/%h exp=%0d/%h", c, cdb_rob_id, cdb_val, m_rob, m_val);
      end
      if (m_valid) begin
        checks++; if (cdb_src !== 2'(m_src)) begin errors++; $display("FAIL rnd_src cyc=%0d got=%0d exp=%0d", c, cdb_src, m_src); end
      end
      checks++; if (src_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, src_ready, exp_ready()); end
      for (int i = 0; i < NS; i++) begin
        if (!src_valid[i] || m_acc[i]) begin
          if ($urandom_range(0, 2) != 0) set_src(i, 1'b1, 4'($urandom), $urandom);
          else src_valid[i] = 1'b0;
        end
      end
    end
`ifdef CDB_STATS_EN
    for (int i = 0; i < NS; i++) begin
      checks++; if (stat_grants[i*32 +: 32] !== 32'(m_grants[i]) || stat_stalls[i*32 +: 32] !== 32'(m_stalls[i])) begin
        errors++;
        $display("FAIL rnd_stats src=%0d got=%0d/%0d exp=%0d/%0d", i, stat_grants[i*32 +: 32], stat_stalls[i*32 +: 32],
                 m_grants[i], m_stalls[i]);
      end
    end
`endif
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    src_valid = '0; src_rob_id = '0; src_val = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_rdy_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
